// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined 8-op bitwise logic unit with valid/ready on input and output.
// Optional LOGIC_FLAGS_EN macro adds registered zero/parity flags alongside the result.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic             out_par
);

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_y;
  logic             w_s1_take;
  logic             w_s2_take;

  // S2 frees up when empty or draining; S1 may refill whenever S2 can take its beat.
  assign w_s2_take = !r_s2_valid || out_ready;
  assign w_s1_take = !r_s1_valid || w_s2_take;
  assign in_ready  = w_s1_take;

  always_comb begin
    w_y = '0;
    case (r_s1_op)
      OP_NOT:  w_y = ~r_s1_a;
      OP_AND:  w_y = r_s1_a & r_s1_b;
      OP_OR:   w_y = r_s1_a | r_s1_b;
      OP_XOR:  w_y = r_s1_a ^ r_s1_b;
      OP_NAND: w_y = ~(r_s1_a & r_s1_b);
      OP_NOR:  w_y = ~(r_s1_a | r_s1_b);
      OP_XNOR: w_y = ~(r_s1_a ^ r_s1_b);
      OP_PASS: w_y = r_s1_a;
      default: w_y = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_take) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= in_op;
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
      end
    end
  end

  // NOTE: the result register is reset too, because out_y must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
    end else if (w_s2_take) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_y <= w_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (r_s2_valid && out_ready) r_cnt <= r_cnt + CNT_W'(1);
  end

`ifdef LOGIC_FLAGS_EN
  logic r_zero;
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b1;
      r_par  <= 1'b0;
    end else if (w_s2_take && r_s1_valid) begin
      r_zero <= (w_y == '0);
      r_par  <= ^w_y;
    end
  end

  assign out_zero = r_zero;
  assign out_par  = r_par;
`else
  assign out_zero = 1'b0;
  assign out_par  = 1'b0;
`endif

  assign out_valid = r_s2_valid;
  assign out_y     = r_y;
  assign out_cnt   = r_cnt;

endmodule
